// File: rtl/updn_ctr_pkg.sv
// Shared constants for the programmable-modulus up/down counter.
// Holds the boundary-mode encodings and the default parameter values.
package updn_ctr_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_PRE_W = 4;

endpackage

// File: rtl/ctr_prescaler.sv
// Count-enable prescaler: emits one tick every prescale+1 enabled cycles.
// clear (driven by load) discards partial progress and suppresses the tick.
module ctr_prescaler
    import updn_ctr_pkg::*;
#(
    parameter int unsigned PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             clear,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    assign tick = cen & ~clear & (cnt_q == prescale);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cen) begin
            cnt_d = tick ? '0 : cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/updn_mod_ctr.sv
// Up/down counter over 0..limit with wrap or saturate boundary behaviour,
// a prescaled count enable, a one-cycle boundary pulse and sticky flags.
module updn_mod_ctr
    import updn_ctr_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic             cen,
    input  logic             up_dn,
    input  logic             mode,
    input  logic [PRE_W-1:0] prescale,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tercnt,
    output logic             term_evt,
    output logic             ovf,
    output logic             unf
);

    logic             tick;
    logic             at_top;
    logic             at_zero;
    logic             ovf_evt;
    logic             unf_evt;

    logic [WIDTH-1:0] count_q, count_d;
    logic             term_evt_q, term_evt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    ctr_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .clear    (load),
        .prescale (prescale),
        .tick     (tick)
    );

    // >= so a limit lowered below the current count still reads as the top.
    assign at_top  = (count_q >= limit);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (load) begin
            count_d = (data > limit) ? limit : data;
        end else if (tick) begin
            if (up_dn) begin
                if (!at_top) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    ovf_evt = 1'b1;
                    count_d = (mode == MODE_SAT) ? limit : '0;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    unf_evt = 1'b1;
                    count_d = (mode == MODE_SAT) ? '0 : limit;
                end
            end
        end
    end

    // A boundary event in the same cycle as clr_flags keeps the flag set.
    always_comb begin
        term_evt_d = ovf_evt | unf_evt;
        ovf_d      = ovf_evt | (ovf_q & ~clr_flags);
        unf_d      = unf_evt | (unf_q & ~clr_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            term_evt_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            term_evt_q <= term_evt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign count    = count_q;
    assign term_evt = term_evt_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign tercnt   = up_dn ? at_top : at_zero;

endmodule

// File: doc/updn_mod_ctr.md
# updn_mod_ctr

Parametrised up/down counter with programmable modulus, wrap or saturate boundary mode, a cen prescaler, and sticky overflow/underflow flags. It is the next generation of the team's DW03-style up/down counter, for timers, address sequencers and event counters whose range is set at run time rather than fixed at 2^WIDTH. One clock domain; all state is updated on the rising edge of clk.

## Interface
- WIDTH, 8, counter and limit width in bits (>= 2)
- PRE_W, 4, prescaler ratio width in bits (>= 1)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- data  input  WIDTH  load value
- limit  input  WIDTH  upper bound; count range is 0..limit inclusive
- load  input  1  active-high synchronous load of data
- cen  input  1  count enable, gated through the prescaler
- up_dn  input  1  1 = count up, 0 = count down
- mode  input  1  0 = wrap (MODE_WRAP), 1 = saturate (MODE_SAT)
- prescale  input  PRE_W  tick every prescale+1 enabled cycles
- clr_flags  input  1  clears ovf and unf
- count  output  WIDTH  current count, registered
- tercnt  output  1  combinational; direction-aware terminal count
- term_evt  output  1  registered one-cycle pulse on a boundary event
- ovf  output  1  sticky overflow flag, registered
- unf  output  1  sticky underflow flag, registered

## Operation
- Priority, highest first: rst, load, tick. clr_flags is evaluated in parallel with these.
- rst: count=0, prescaler counter=0, term_evt=0, ovf=0, unf=0.
- load: count <= min(data, limit). Prescaler counter cleared. No flag change and no term_evt.
- Prescaler: while cen=1 and load=0, the prescaler counter increments.
  - When the prescaler counter == prescale, a tick is generated and the counter returns to 0.
  - prescale=0 gives a tick on every cen cycle.
  - cen=0 holds the prescaler counter.
- Tick, up (up_dn=1):
  - count < limit: count+1.
  - count >= limit, wrap mode: count <= 0.
  - count >= limit, saturate mode: count <= limit.
  - Either boundary case sets ovf and pulses term_evt.
- Tick, down (up_dn=0):
  - count > 0: count-1.
  - count == 0, wrap mode: count <= limit.
  - count == 0, saturate mode: count holds at 0.
  - Either boundary case sets unf and pulses term_evt.
- tercnt = (up_dn & count>=limit) | (~up_dn & count==0).
- Flags: clr_flags clears ovf and unf. If a boundary event occurs in the same cycle, the set wins.
- limit lowered below count: the next up tick is a boundary event. A down tick decrements normally from the current count.
- limit=0: every tick is a boundary event, and count stays 0 in both modes.
- mode, up_dn, limit and prescale are sampled every cycle with no latching. A change takes effect on the next tick.
- Arithmetic is unsigned WIDTH-bit. No intermediate value exceeds limit, so there is no carry out.

## Timing
- Outputs are registered, except tercnt, which follows count and up_dn combinationally.
- load takes effect on count in the cycle after it is sampled.
- A tick edge updates count, and ovf/unf/term_evt assert from the same edge. term_evt is high for exactly one cycle per event.
- rst asserted mid-count or mid-prescale returns all state to reset values at the next edge. Pending prescaler progress is discarded.
- Consecutive boundary ticks (limit=0, prescale=0) keep term_evt high on every cycle in which a tick occurs.

## Structure
- Package updn_ctr_pkg holds:
  - constants MODE_WRAP=1'b0 and MODE_SAT=1'b1;
  - the default WIDTH and PRE_W values.
- Sub-module ctr_prescaler (PRE_W) takes clk, rst, cen, clear, prescale and outputs tick.
  - clear is driven by load.
- The top module contains the count register, the boundary logic and the flags.

## Test plan
- Reset with WIDTH=8, PRE_W=4: drive rst=1 for 2 cycles, then release. Required: count=0, ovf=unf=term_evt=0. With up_dn=1, tercnt=0.
- Wrap up: limit=9, mode=0, prescale=0, cen=1, up_dn=1, run 12 cycles from 0. Required: count runs 0..9 then 0, 1, 2. term_evt is high only at the 9→0 edge, and ovf stays 1.
- Saturate down: load data=3, mode=1, up_dn=0, cen=1, run 6 cycles. Required: count runs 3, 2, 1, 0, 0, 0. unf is set at the first held cycle, and term_evt pulses every held tick.
- Prescaler: prescale=3, cen=1 continuously, up from 0 with limit=255. Required: count advances once per 4 cycles. Dropping cen for 2 cycles mid-period delays the next tick by exactly 2 cycles.
- Load clamp: limit=20, load data=50. Required: count=20 and tercnt=1 with up_dn=1. The next up tick in wrap mode gives count=0 and ovf=1.
- Flag race: with ovf=1, assert clr_flags in the same cycle as an overflow tick. Required: ovf stays 1. clr_flags with no event clears ovf and unf to 0 on the next edge.
